// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access path: sizes, grant
// and FSM encodings, and the byte-address legality check.
package imem_pkg;

  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  // Word aligned and no address bits set above the word-index field.
  function automatic logic addr_ok(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi_s;
    hi_s = addr >> (addr_w + 32'sd2);
    return (addr[1:0] == 2'b00) && (hi_s == 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the input not granted last wins.
// The history only advances when the caller strobes update.
module rr_arbiter2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  input  logic update,
  output logic gnt_0,
  output logic gnt_1
);

  grant_e last_grant_r;

  // Grant selection from the current requests and the grant history
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    case ({req_1, req_0})
      2'b01: gnt_0 = 1'b1;
      2'b10: gnt_1 = 1'b1;
      2'b11: begin
        if (last_grant_r == LOADER) begin
          gnt_0 = 1'b1;
        end else begin
          gnt_1 = 1'b1;
        end
      end
      default: begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
      end
    endcase
  end

  // Grant history; reset to input 1 so input 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= LOADER;
    end else if (update) begin
      last_grant_r <= gnt_1 ? LOADER : FETCH;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares one single-port synchronous instruction RAM between the fetch port
// and the loader port; one outstanding transaction, registered responses.
module imem_access_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [31:0]       f_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_rsp_valid,
  input  logic              l_rsp_ready,
  output logic [31:0]       l_rsp_data,
  output logic              l_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [29:0] LAST_WORD = 30'(DEPTH - 1);

  state_e      state_r, state_s;
  grant_e      owner_r;
  logic        err_r, we_r;
  logic        idle_s, gnt_f_s, gnt_l_s, accept_s, ok_s, rsp_ready_s;
  logic [31:0] sel_addr_s, cap_data_s;
  logic        f_rsp_valid_r, f_rsp_err_r, l_rsp_valid_r, l_rsp_err_r;
  logic [31:0] f_rsp_data_r, l_rsp_data_r;

  // Readies must read 0 while reset is held, even with requests pending.
  assign idle_s = (state_r == IDLE) && rst_n;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_0  (f_req_valid & idle_s),
    .req_1  (l_req_valid & idle_s),
    .update (accept_s),
    .gnt_0  (gnt_f_s),
    .gnt_1  (gnt_l_s)
  );

  assign accept_s   = gnt_f_s | gnt_l_s;
  assign sel_addr_s = gnt_l_s ? l_addr : f_addr;
  // The DEPTH bound matters only if DEPTH is not a power of two.
  assign ok_s       = addr_ok(sel_addr_s, ADDR_W) && (sel_addr_s[31:2] <= LAST_WORD);

  assign f_req_ready = gnt_f_s;
  assign l_req_ready = gnt_l_s;
  assign mem_en      = accept_s & ok_s;
  assign mem_we      = accept_s & ok_s & gnt_l_s & l_we;
  assign mem_addr    = sel_addr_s[ADDR_W+1:2];
  assign mem_wdata   = gnt_l_s ? l_wdata : 32'd0;

  assign rsp_ready_s = (owner_r == LOADER) ? l_rsp_ready : f_rsp_ready;
  assign cap_data_s  = (err_r || we_r) ? 32'd0 : mem_rdata;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = MEM_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      MEM_WAIT: state_s = RESP;
      RESP: begin
        if (rsp_ready_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Transaction attributes latched at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= FETCH;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
    end else if (accept_s) begin
      owner_r <= gnt_l_s ? LOADER : FETCH;
      err_r   <= ~ok_s;
      we_r    <= gnt_l_s & l_we;
    end else begin
      owner_r <= owner_r;
      err_r   <= err_r;
      we_r    <= we_r;
    end
  end

  // Response registers: loaded in MEM_WAIT, released on the owner's ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rsp_valid_r <= 1'b0;
      f_rsp_data_r  <= 32'd0;
      f_rsp_err_r   <= 1'b0;
      l_rsp_valid_r <= 1'b0;
      l_rsp_data_r  <= 32'd0;
      l_rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        MEM_WAIT: begin
          if (owner_r == LOADER) begin
            l_rsp_valid_r <= 1'b1;
            l_rsp_data_r  <= cap_data_s;
            l_rsp_err_r   <= err_r;
          end else begin
            f_rsp_valid_r <= 1'b1;
            f_rsp_data_r  <= cap_data_s;
            f_rsp_err_r   <= err_r;
          end
        end
        RESP: begin
          if (rsp_ready_s) begin
            f_rsp_valid_r <= 1'b0;
            l_rsp_valid_r <= 1'b0;
          end else begin
            f_rsp_valid_r <= f_rsp_valid_r;
            l_rsp_valid_r <= l_rsp_valid_r;
          end
        end
        default: begin
          f_rsp_valid_r <= f_rsp_valid_r;
          l_rsp_valid_r <= l_rsp_valid_r;
        end
      endcase
    end
  end

  assign f_rsp_valid = f_rsp_valid_r;
  assign f_rsp_data  = f_rsp_data_r;
  assign f_rsp_err   = f_rsp_err_r;
  assign l_rsp_valid = l_rsp_valid_r;
  assign l_rsp_data  = l_rsp_data_r;
  assign l_rsp_err   = l_rsp_err_r;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter: directed cases, then random traffic
// against a reference model of arbitration, address legality and RAM contents.
module tb_imem_access_arbiter;

  localparam logic [31:0] MEM_BYTES = 32'h0000_1000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        f_req_valid = 1'b0, f_rsp_ready = 1'b0;
  logic [31:0] f_addr = 32'd0;
  logic        l_req_valid = 1'b0, l_we = 1'b0, l_rsp_ready = 1'b0;
  logic [31:0] l_addr = 32'd0, l_wdata = 32'd0;
  logic        f_req_ready, f_rsp_valid, f_rsp_err;
  logic        l_req_ready, l_rsp_valid, l_rsp_err;
  logic [31:0] f_rsp_data, l_rsp_data, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;

  imem_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
    .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready),
    .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM seen by the DUT
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  typedef struct {
    bit          port;   // 0 fetch, 1 loader
    logic [31:0] data;
    bit          err;
    int          acc;
  } exp_t;
  exp_t        q[$];
  bit          busy = 1'b0;
  bit          last_l = 1'b1;
  logic [31:0] ref_mem [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: predicts grants/RAM strobes at accept, checks responses each cycle
  always @(negedge clk) begin
    bit          wf, wl, ok, efv, elv;
    logic [31:0] a;
    exp_t        e;
    if (rst_n) begin
      wf = 1'b0; wl = 1'b0;
      if (!busy) begin
        if (f_req_valid && l_req_valid) begin
          wf = last_l; wl = !last_l;
        end else begin
          wf = f_req_valid; wl = l_req_valid;
        end
      end
      chk("f_req_ready", {31'd0, f_req_ready}, {31'd0, wf});
      chk("l_req_ready", {31'd0, l_req_ready}, {31'd0, wl});
      if (wf || wl) begin
        a  = wl ? l_addr : f_addr;
        ok = (a[1:0] == 2'b00) && (a < MEM_BYTES);
        e.port = wl; e.acc = cyc; e.err = !ok; e.data = 32'd0;
        if (ok && wl && l_we) ref_mem[a[11:2]] = l_wdata;
        else if (ok)          e.data = ref_mem[a[11:2]];
        chk("mem_en", {31'd0, mem_en}, {31'd0, ok});
        if (ok) begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, wl && l_we});
          chk("mem_addr", {22'd0, mem_addr}, {22'd0, a[11:2]});
          if (wl && l_we) chk("mem_wdata", mem_wdata, l_wdata);
        end
        q.push_back(e);
        busy = 1'b1;
        last_l = wl;
      end else begin
        chk("mem_en_quiet", {30'd0, mem_en, mem_we}, 32'd0);
      end
      efv = (q.size() > 0) && (q[0].port == 1'b0) && (cyc >= q[0].acc + 2);
      elv = (q.size() > 0) && (q[0].port == 1'b1) && (cyc >= q[0].acc + 2);
      chk("f_rsp_valid", {31'd0, f_rsp_valid}, {31'd0, efv});
      chk("l_rsp_valid", {31'd0, l_rsp_valid}, {31'd0, elv});
      if (efv) begin
        chk("f_rsp_data", f_rsp_data, q[0].data);
        chk("f_rsp_err", {31'd0, f_rsp_err}, {31'd0, q[0].err});
        if (f_rsp_ready) begin void'(q.pop_front()); busy = 1'b0; end
      end else if (elv) begin
        chk("l_rsp_data", l_rsp_data, q[0].data);
        chk("l_rsp_err", {31'd0, l_rsp_err}, {31'd0, q[0].err});
        if (l_rsp_ready) begin void'(q.pop_front()); busy = 1'b0; end
      end
    end
  end

  // One cycle of stimulus; called at posedge+1
  task automatic step(input logic fv, input logic [31:0] fa, input logic lv, input logic lwe,
                      input logic [31:0] la, input logic [31:0] ld, input logic frr, input logic lrr);
    f_req_valid = fv; f_addr = fa; l_req_valid = lv; l_we = lwe; l_addr = la; l_wdata = ld;
    f_rsp_ready = frr; l_rsp_ready = lrr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, rr, rr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {22'd0, f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid,
                         f_rsp_err, l_rsp_err, mem_en, mem_we, 2'b00}, 32'd0);
    chk({tag, "_fdata"}, f_rsp_data, 32'd0);
    chk({tag, "_ldata"}, l_rsp_data, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
      1:       return $urandom | MEM_BYTES;
      2:       return 32'h0000_0FFC;
      default: return $urandom_range(0, 15) * 4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = (i * 32'h9E37_79B1) ^ 32'h0000_1234;
      ref_mem[i] = ram[i];
    end
    ram[2] = 32'h0050_0093;
    ref_mem[2] = 32'h0050_0093;

    f_req_valid = 1'b1;      // readies must stay low while reset is held
    #1 check_all_zero("reset");
    f_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // First fetch, response held while the consumer stalls
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(2, 1'b1);

    // Sustained conflict: fetch, loader, fetch, loader ...
    for (int i = 0; i < 12; i++)
      step(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Loader write then fetch of the same word
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Misaligned, out of range, last word, misaligned loader write
    step(1'b1, 32'h6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'hFFC, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h2, 32'h1234_5678, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 6, rand_addr(), $urandom_range(0, 9) < 6,
           1'($urandom_range(0, 1)), rand_addr(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    idle(6, 1'b1);

    // Reset while a loader response is being held
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !l_rsp_valid; i++) idle(1, 1'b0);
    chk("l_rsp_valid_before_reset", {31'd0, l_rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    q.delete(); busy = 1'b0; last_l = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h8, 1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b1, 1'b1);
    step(1'b1, 32'h8, 1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b1, 1'b1);
    step(1'b1, 32'h8, 1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b1, 1'b1);
    step(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(6, 1'b1);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Controller that shares one single-port synchronous instruction RAM between two requesters: the core fetch port (read-only) and the program loader/debug port (read/write).
- Sits between the fetch stage and the instruction RAM and replaces direct combinational PC indexing.
- Converts byte addresses to word indices, rejects misaligned and out-of-range accesses, arbitrates round-robin and returns one registered response per request with valid/ready backpressure.

Parameters:
- DEPTH, 1024, RAM depth in 32-bit words.
- ADDR_W, 10, word-index width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_addr  in  32  fetch byte address (PC)
- f_rsp_valid  out  1  fetch response valid
- f_rsp_ready  in  1  fetch consumer accepts response
- f_rsp_data  out  32  fetched instruction
- f_rsp_err  out  1  misaligned or out-of-range fetch
- l_req_valid  in  1  loader request valid
- l_req_ready  out  1  loader request accepted this cycle
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_rsp_valid  out  1  loader response valid
- l_rsp_ready  in  1  loader accepts response
- l_rsp_data  out  32  read data; 0 for writes and errors
- l_rsp_err  out  1  misaligned or out-of-range loader access
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word index = byte addr[ADDR_W+1:2]
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, rst_n=0): state IDLE; all *_req_ready, *_rsp_valid, *_rsp_err, mem_en, mem_we = 0; rsp data regs = 0; last_grant = LOADER, so fetch wins the first conflict. Reset mid-transaction drops the in-flight response; a write already presented to the RAM is not reverted.
- FSM states: IDLE, MEM_WAIT, RESP.
- IDLE: the winner's req_ready=1 combinationally in the same cycle as its req_valid; the loser's ready=0.
  - Only one valid: it wins.
  - Both valid: the requester not equal to last_grant wins; last_grant updates on every grant.
- Address check at accept:
  - err if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
  - Err request: mem_en=0, go to MEM_WAIT with err flag latched.
  - Valid request: mem_en=1, mem_we=l_we (always 0 for fetch), mem_addr and mem_wdata driven combinationally that cycle, go to MEM_WAIT.
- MEM_WAIT (1 cycle): capture the response into the owner's response regs.
  - data = mem_rdata for a good read; 0 for write or err.
  - err = latched flag.
  - Set owner rsp_valid=1 at the next edge and go to RESP.
  - Accept at cycle T gives rsp_valid visible at T+2 edge-aligned (first cycle of RESP).
- RESP: hold rsp_valid, data and err stable until rsp_ready=1, then clear rsp_valid and return to IDLE. No new request is accepted while in MEM_WAIT or RESP; one outstanding transaction total.
- Throughput: best case one transaction per 3 cycles.
- The non-owner port's rsp_valid stays 0. mem_en=0 outside accept cycles.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH and IMEM_ADDR_W constants.
  - Grant enum {FETCH, LOADER}.
  - State enum {IDLE, MEM_WAIT, RESP}.
  - Helper function addr_ok(addr) for the alignment and range check.
- One natural sub-module, rr_arbiter2: 2-input round-robin arbiter with a last_grant register and an update-on-grant strobe, reusable for the data-memory port.

Test Plan:
- Reset release, f_req_valid=1, f_addr=0x8, RAM[2]=0x00500093 -> f_req_ready=1 same cycle; mem_addr=2; f_rsp_valid with data 0x00500093, err=0; held 3 cycles while f_rsp_ready=0.
- Both valid from first IDLE after reset -> fetch granted first, loader second; sustained conflict alternates F,L,F,L and neither port waits more than one transaction.
- Loader write l_addr=0x10, l_wdata=0xDEADBEEF, then fetch 0x10 -> mem_we=1 for 1 cycle at index 4; the fetch returns 0xDEADBEEF; the write response has data 0 and err=0.
- f_addr=0x6 (misaligned) and f_addr=0x1000 (out of range, DEPTH=1024) -> mem_en stays 0; f_rsp_err=1; f_rsp_data=0.
- rst_n pulsed low during RESP with l_rsp_valid=1 -> all outputs 0 immediately; the next request after release is serviced normally and gets fetch priority.
- f_addr=0xFFC (last word) -> mem_addr=1023, err=0.
